// File: rtl/fft_out_serializer_pkg.sv
// Shared types for the FFT output path: complex bin format, index width helper, drop counter width.
package fft_out_serializer_pkg;

   localparam int CPLX_W     = 16;
   localparam int DROP_CNT_W = 8;

   typedef struct packed {
      logic signed [CPLX_W-1:0] re;
      logic signed [CPLX_W-1:0] im;
   } complex_product_t;

   function automatic int FFT_IDX_W(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/fft_out_serializer_if.sv
// Frame-in / serial-bin-out bundle; slave is the serializer, master is the FFT + equalizer side.
interface fft_out_serializer_if #(
   parameter int N = 8
);
   import fft_out_serializer_pkg::*;
   localparam int IDX_W = FFT_IDX_W(N);

   logic                          in_valid;
   complex_product_t [N-1:0]      fft_in;
   complex_product_t              out_data;
   logic [IDX_W-1:0]              out_index;
   logic                          out_valid;
   logic                          out_ready;
   logic                          out_last;
   logic                          overflow;
   logic [DROP_CNT_W-1:0]         drop_count;

   modport slave (
      input  in_valid, fft_in, out_ready,
      output out_data, out_index, out_valid, out_last, overflow, drop_count
   );

   modport master (
      output in_valid, fft_in, out_ready,
      input  out_data, out_index, out_valid, out_last, overflow, drop_count
   );
endinterface

// File: rtl/fft_frame_bank.sv
// One N-bin frame store: whole-frame load in a single clk, combinational indexed read.
// Contents are deliberately not reset; the owner tracks validity.
module fft_frame_bank
   import fft_out_serializer_pkg::*;
#(
   parameter int N     = 8,
   parameter int IDX_W = FFT_IDX_W(N)
) (
   input  logic                     clk,
   input  logic                     load,
   input  complex_product_t [N-1:0] load_data,
   input  logic [IDX_W-1:0]         rd_idx,
   output complex_product_t         rd_data
);

   complex_product_t [N-1:0] mem;

   always_ff @(posedge clk) begin
      if (load) begin
         mem <= load_data;
      end
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/fft_out_serializer.sv
// Ping-pong buffer turning parallel FFT frames into one bin per beat; first beat 1 clk after capture.
// Holds the beat while out_ready=0; a frame arriving with both banks busy is dropped and counted.
module fft_out_serializer
   import fft_out_serializer_pkg::*;
#(
   parameter int N        = 8,
   parameter bit FFTSHIFT = 1'b0,
   parameter int IDX_W    = FFT_IDX_W(N)
) (
   input  logic                 clk,
   input  logic                 reset,
   fft_out_serializer_if.slave  bus
);

   logic [1:0]             bank_full;
   logic [1:0]             bank_full_nxt;
   logic                   wr_bank;
   logic                   rd_bank;
   logic [IDX_W-1:0]       rd_pos;
   logic [IDX_W-1:0]       rd_idx;
   logic                   valid;
   logic                   transfer;
   logic                   last_beat;
   logic                   capture;
   logic                   drop;
   logic                   overflow_q;
   logic [DROP_CNT_W-1:0]  drop_cnt;
   complex_product_t       rd_data0;
   complex_product_t       rd_data1;

   assign valid  = bank_full[rd_bank];
   assign rd_idx = FFTSHIFT ? (rd_pos + IDX_W'(N/2)) : rd_pos;

   always_comb begin
      transfer      = valid & bus.out_ready;
      last_beat     = transfer && (rd_pos == IDX_W'(N-1));
      // A release of the bank being written frees it in the same clk.
      capture       = bus.in_valid &&
                      (!bank_full[wr_bank] || (last_beat && (rd_bank == wr_bank)));
      drop          = bus.in_valid && !capture;
      bank_full_nxt = bank_full;
      if (last_beat) begin
         bank_full_nxt[rd_bank] = 1'b0;
      end
      if (capture) begin
         bank_full_nxt[wr_bank] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bank_full  <= 2'b00;
         wr_bank    <= 1'b0;
         rd_bank    <= 1'b0;
         rd_pos     <= '0;
         overflow_q <= 1'b0;
         drop_cnt   <= '0;
      end else begin
         bank_full  <= bank_full_nxt;
         overflow_q <= drop;
         if (capture) begin
            wr_bank <= ~wr_bank;
         end
         if (transfer) begin
            rd_pos <= last_beat ? '0 : rd_pos + IDX_W'(1);
         end
         if (last_beat) begin
            rd_bank <= ~rd_bank;
         end
         if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_CNT_W'(1);
         end
      end
   end

   fft_frame_bank #(.N(N), .IDX_W(IDX_W)) u_bank0 (
      .clk       (clk),
      .load      (capture && !wr_bank),
      .load_data (bus.fft_in),
      .rd_idx    (rd_idx),
      .rd_data   (rd_data0)
   );

   fft_frame_bank #(.N(N), .IDX_W(IDX_W)) u_bank1 (
      .clk       (clk),
      .load      (capture && wr_bank),
      .load_data (bus.fft_in),
      .rd_idx    (rd_idx),
      .rd_data   (rd_data1)
   );

   // Index reads as zero while idle so the reset value holds for either bin ordering.
   assign bus.out_valid  = valid;
   assign bus.out_index  = valid ? rd_idx : '0;
   assign bus.out_last   = valid && (rd_pos == IDX_W'(N-1));
   assign bus.out_data   = rd_bank ? rd_data1 : rd_data0;
   assign bus.overflow   = overflow_q;
   assign bus.drop_count = drop_cnt;

endmodule
